uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between two byte requesters, the arbiter and a UART transmitter.
// Handshake: a requester raises reqN with dataN stable and holds both until a one-cycle ackN; dropping reqN earlier withdraws it.
interface uart_tx_arbiter_if;
  logic       req0;
  logic [7:0] data0;
  logic       ack0;
  logic       req1;
  logic [7:0] data1;
  logic       ack1;
  logic       xmitH;
  logic [7:0] xmit_dataH;
  logic       xmit_doneH;
  logic       busy;
  logic       grant_id;
  logic       err_timeout;

  modport master (
    output req0, data0, req1, data1, xmit_doneH,
    input  ack0, ack1, xmitH, xmit_dataH, busy, grant_id, err_timeout
  );

  modport slave (
    input  req0, data0, req1, data1, xmit_doneH,
    output ack0, ack1, xmitH, xmit_dataH, busy, grant_id, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from two requesters into one UART transmitter,
// with a start-of-frame watchdog and a programmable idle gap between frames.
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 8,
  parameter int GAP_CYCLES    = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  uart_tx_arbiter_if.slave   bus,
  output logic [2:0]         stateDbg
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4
  } stateT;

  localparam logic [3:0] START_LAST = 4'(START_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
  // A zero-length gap skips the GAP state entirely.
  localparam stateT FRAME_EXIT = (GAP_CYCLES == 0) ? IDLE : GAP;

  stateT      state;
  logic       lastGnt;
  logic [3:0] startCnt;
  logic [7:0] gapCnt;
  logic       xmitReg;
  logic       ack0Reg;
  logic       ack1Reg;
  logic       gntReg;
  logic       errReg;
  logic [7:0] dataReg;
  logic       anyReq;
  logic       pick;

  always_comb begin
    anyReq = bus.req0 | bus.req1;
    pick   = (bus.req0 & bus.req1) ? ~lastGnt : bus.req1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      lastGnt  <= 1'b1;
      startCnt <= 4'd0;
      gapCnt   <= 8'd0;
      xmitReg  <= 1'b0;
      ack0Reg  <= 1'b0;
      ack1Reg  <= 1'b0;
      gntReg   <= 1'b0;
      errReg   <= 1'b0;
      dataReg  <= 8'd0;
    end else begin
      xmitReg <= 1'b0;
      ack0Reg <= 1'b0;
      ack1Reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.xmit_doneH && anyReq) begin
            state   <= ISSUE;
            xmitReg <= 1'b1;
            ack0Reg <= ~pick;
            ack1Reg <= pick;
            gntReg  <= pick;
            lastGnt <= pick;
            dataReg <= pick ? bus.data1 : bus.data0;
          end
        end
        ISSUE: begin
          state    <= WAIT_START;
          startCnt <= 4'd0;
        end
        WAIT_START: begin
          // A start seen on the last allowed cycle still wins over the timeout.
          if (!bus.xmit_doneH) begin
            state <= WAIT_DONE;
          end else if (startCnt == START_LAST) begin
            errReg <= 1'b1;
            state  <= FRAME_EXIT;
            gapCnt <= 8'd0;
          end else begin
            startCnt <= startCnt + 4'd1;
          end
        end
        WAIT_DONE: begin
          if (bus.xmit_doneH) begin
            state  <= FRAME_EXIT;
            gapCnt <= 8'd0;
          end
        end
        GAP: begin
          if (gapCnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gapCnt <= gapCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.xmitH       = xmitReg;
  assign bus.ack0        = ack0Reg;
  assign bus.ack1        = ack1Reg;
  assign bus.xmit_dataH  = dataReg;
  assign bus.grant_id    = gntReg;
  assign bus.err_timeout = errReg;
  assign bus.busy        = (state != IDLE);
  assign stateDbg        = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Random two-requester traffic against two arbiter instances (default and zero-gap),
// checked every cycle against a timestamp-based model of frames, gaps and grants.
module tb_uart_tx_arbiter;

  localparam int INF   = 32'h7fff_ffff;
  localparam int NCYC  = 4000;
  localparam int ST_A  = 8;
  localparam int GAP_A = 2;
  localparam int ST_B  = 5;
  localparam int GAP_B = 0;

  // clock / reset
  logic sys_clk = 1'b0;
  logic rstA;
  logic rstB;
  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter_if busA ();
  uart_tx_arbiter_if busB ();
  logic [2:0] dbgA;
  logic [2:0] dbgB;

  uart_tx_arbiter dutA (
    .sys_clk  (sys_clk),
    .sys_rst  (rstA),
    .bus      (busA.slave),
    .stateDbg (dbgA)
  );

  uart_tx_arbiter #(.START_TIMEOUT(ST_B), .GAP_CYCLES(GAP_B)) dutB (
    .sys_clk  (sys_clk),
    .sys_rst  (rstB),
    .bus      (busB.slave),
    .stateDbg (dbgB)
  );

  typedef struct packed {
    logic       xmitH;
    logic       ack0;
    logic       ack1;
    logic       busy;
    logic       gid;
    logic       err;
    logic [7:0] data;
  } obsT;

  int nChecks = 0;
  int nErrors = 0;

  // driven stimulus per lane
  logic       rst  [2];
  logic       rq0  [2];
  logic       rq1  [2];
  logic [7:0] dt0  [2];
  logic [7:0] dt1  [2];
  logic       done [2];
  int         lowStart [2];
  int         lowEnd   [2];

  // reference model: when the arbiter is idle, when a frame issues, what it carries
  int         idleFrom  [2];
  int         pendIssue [2];
  int         errFrom   [2];
  logic       lastGnt   [2];
  logic       win       [2];
  logic       gid       [2];
  logic [7:0] xdata     [2];
  logic [7:0] expQ0 [$];
  logic [7:0] expQ1 [$];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int stOf(input int l);
    return (l == 0) ? ST_A : ST_B;
  endfunction

  function automatic int gapOf(input int l);
    return (l == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic obsT sampleLane(input int l);
    obsT o;
    if (l == 0) begin
      o.xmitH = busA.xmitH; o.ack0 = busA.ack0; o.ack1 = busA.ack1; o.busy = busA.busy;
      o.gid = busA.grant_id; o.err = busA.err_timeout; o.data = busA.xmit_dataH;
    end else begin
      o.xmitH = busB.xmitH; o.ack0 = busB.ack0; o.ack1 = busB.ack1; o.busy = busB.busy;
      o.gid = busB.grant_id; o.err = busB.err_timeout; o.data = busB.xmit_dataH;
    end
    return o;
  endfunction

  // driver
  task automatic driveLane(input int l);
    if (l == 0) begin
      rstA = rst[0]; busA.req0 = rq0[0]; busA.data0 = dt0[0];
      busA.req1 = rq1[0]; busA.data1 = dt1[0]; busA.xmit_doneH = done[0];
    end else begin
      rstB = rst[1]; busB.req0 = rq0[1]; busB.data0 = dt0[1];
      busB.req1 = rq1[1]; busB.data1 = dt1[1]; busB.xmit_doneH = done[1];
    end
  endtask

  task automatic stepLane(input int l, input int c);
    obsT        o;
    logic       issueNow;
    logic       w;
    int         qn;
    logic [7:0] qv;
    string      p;
    o        = sampleLane(l);
    issueNow = (pendIssue[l] == c);
    p        = (l == 0) ? "A" : "B";

    checkEq({p, ".xmitH"},       32'(o.xmitH), 32'(issueNow));
    checkEq({p, ".ack0"},        32'(o.ack0),  32'(issueNow && !win[l]));
    checkEq({p, ".ack1"},        32'(o.ack1),  32'(issueNow && win[l]));
    checkEq({p, ".busy"},        32'(o.busy),  32'(c < idleFrom[l]));
    checkEq({p, ".grant_id"},    32'(o.gid),   32'(gid[l]));
    checkEq({p, ".xmit_dataH"},  32'(o.data),  32'(xdata[l]));
    checkEq({p, ".err_timeout"}, 32'(o.err),   32'(c >= errFrom[l]));

    // scoreboard: every start pulse must match a granted byte, in order
    if (o.xmitH) begin
      qv = 8'd0;
      if (l == 0) begin qn = expQ0.size(); if (qn > 0) qv = expQ0.pop_front(); end
      else        begin qn = expQ1.size(); if (qn > 0) qv = expQ1.pop_front(); end
      checkEq({p, ".frameQueued"}, 32'(qn), 32'd1);
      if (qn > 0) checkEq({p, ".frameByte"}, 32'(o.data), 32'(qv));
    end

    // transmitter behaviour: start after 1..ST cycles or never (timeout), plus idle busy stretches
    if (issueNow) begin
      if ($urandom_range(0, 5) == 0) begin
        lowStart[l] = c;
        lowEnd[l]   = c;
      end else begin
        lowStart[l] = c + int'($urandom_range(1, stOf(l)));
        lowEnd[l]   = lowStart[l] + int'($urandom_range(1, 12));
      end
    end else if (c >= idleFrom[l] && c >= lowEnd[l] && $urandom_range(0, 19) == 0) begin
      lowStart[l] = c;
      lowEnd[l]   = c + int'($urandom_range(1, 6));
    end
    done[l] = !(c >= lowStart[l] && c < lowEnd[l]);
    rst[l]  = (c < 3) || ($urandom_range(0, 249) == 0);

    // requesters: hold until ack, occasionally withdraw
    if (rq0[l]) begin
      if ((issueNow && !win[l]) || $urandom_range(0, 39) == 0) rq0[l] = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      rq0[l] = 1'b1;
      dt0[l] = 8'($urandom);
    end
    if (rq1[l]) begin
      if ((issueNow && win[l]) || $urandom_range(0, 39) == 0) rq1[l] = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      rq1[l] = 1'b1;
      dt1[l] = 8'($urandom);
    end
    driveLane(l);

    // model update from the inputs just driven for this cycle
    if (rst[l]) begin
      idleFrom[l]  = c + 1;
      pendIssue[l] = -1;
      lastGnt[l]   = 1'b1;
      gid[l]       = 1'b0;
      xdata[l]     = 8'd0;
      errFrom[l]   = INF;
      if (l == 0) expQ0.delete(); else expQ1.delete();
    end else if (c >= idleFrom[l] && done[l] && (rq0[l] || rq1[l])) begin
      w            = (rq0[l] && rq1[l]) ? !lastGnt[l] : rq1[l];
      lastGnt[l]   = w;
      win[l]       = w;
      gid[l]       = w;
      xdata[l]     = w ? dt1[l] : dt0[l];
      pendIssue[l] = c + 1;
      idleFrom[l]  = INF;
      if (l == 0) expQ0.push_back(xdata[l]); else expQ1.push_back(xdata[l]);
    end else if (issueNow) begin
      if (lowEnd[l] == lowStart[l]) begin
        if (errFrom[l] == INF) errFrom[l] = c + stOf(l) + 1;
        idleFrom[l] = c + stOf(l) + 1 + gapOf(l);
      end else begin
        idleFrom[l] = lowEnd[l] + 1 + gapOf(l);
      end
    end
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      rst[l] = 1'b1; rq0[l] = 1'b0; rq1[l] = 1'b0; dt0[l] = 8'd0; dt1[l] = 8'd0;
      done[l] = 1'b1; lowStart[l] = 0; lowEnd[l] = 0;
      idleFrom[l] = 0; pendIssue[l] = -1; errFrom[l] = INF;
      lastGnt[l] = 1'b1; win[l] = 1'b0; gid[l] = 1'b0; xdata[l] = 8'd0;
      driveLane(l);
    end
    for (int c = 0; c < NCYC; c++) begin
      @(negedge sys_clk);
      for (int l = 0; l < 2; l++) stepLane(l, c);
    end
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
